// File: rtl/packing_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : packing_sync_fifo
//  Purpose  : Single-clock FIFO that packs R = C_DOUT_WIDTH/C_DIN_WIDTH narrow
//             write words into one wide read word (little-endian: the earliest
//             written word occupies the LSB slice). Registered full/empty/count
//             status, sticky overflow/underflow flags, and a read pipeline of
//             1 stage ("LOW_LATENCY") or 3 stages ("HIGH_PERFORMANCE").
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             din, wren      - write word and write request
//             full           - no free din slot
//             rden           - read request (one wide word)
//             dout,dout_valid- read data and its one-cycle valid strobe
//             empty          - fewer than R din words stored
//             count          - number of stored din words
//             overflow       - sticky: a write was dropped
//             underflow      - sticky: a read was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module packing_sync_fifo #(
  parameter int    C_DIN_WIDTH  = 16,
  parameter int    C_DOUT_WIDTH = 32,
  parameter int    C_DEPTH      = 1024,
  parameter string C_RD_PERF    = "LOW_LATENCY"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [C_DIN_WIDTH-1:0]     din,
  input  logic                       wren,
  output logic                       full,
  input  logic                       rden,
  output logic [C_DOUT_WIDTH-1:0]    dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic [$clog2(C_DEPTH):0]   count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_ratio = C_DOUT_WIDTH / C_DIN_WIDTH;
  localparam int c_aw    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam int c_raw   = ((C_DEPTH / c_ratio) > 1) ? $clog2(C_DEPTH / c_ratio) : 1;
  localparam int c_rsh   = $clog2(c_ratio);
  localparam int c_cw    = $clog2(C_DEPTH) + 1;
  localparam logic [c_cw-1:0] c_ratio_cnt = c_cw'(c_ratio);
  localparam logic [c_cw-1:0] c_full_cnt  = c_cw'(C_DEPTH);

  logic [C_DIN_WIDTH-1:0]  mem_q [C_DEPTH];
  logic [c_aw-1:0]         wr_ptr_q;
  logic [c_raw-1:0]        rd_ptr_q;
  logic [c_cw-1:0]         count_q, count_d;
  logic                    full_q, empty_q;
  logic                    overflow_q, underflow_q;
  logic [C_DOUT_WIDTH-1:0] dout_q;
  logic                    dout_valid_q;

  logic                    wr_acc, rd_acc;
  logic [c_aw-1:0]         rd_base;
  logic [C_DOUT_WIDTH-1:0] rd_word;

  // Accept decisions use the registered (pre-edge) status flags, so a write
  // is refused when full even if a read frees space in the same cycle.
  assign wr_acc  = wren & ~full_q;
  assign rd_acc  = rden & ~empty_q;

  // Wide-word read pointer scaled to a din-word address (first word of group).
  assign rd_base = c_aw'(rd_ptr_q) << c_rsh;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < c_ratio; k++) begin
      rd_word[k*C_DIN_WIDTH +: C_DIN_WIDTH] = mem_q[rd_base + c_aw'(k)];
    end
  end

  always_comb begin
    count_d = count_q + c_cw'(wr_acc) - (rd_acc ? c_ratio_cnt : '0);
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + c_raw'(1);
      count_q <= count_d;
      full_q  <= (count_d == c_full_cnt);
      empty_q <= (count_d < c_ratio_cnt);
      if (wren & full_q)  overflow_q  <= 1'b1;
      if (rden & empty_q) underflow_q <= 1'b1;
    end
  end

  // Read pipeline: free-running, each stage carries its own valid bit.
  // The output register only loads when its feeding stage is valid so that
  // dout holds its last value between reads.
  if (C_RD_PERF == "HIGH_PERFORMANCE") begin : g_rd_hp
    logic [C_DOUT_WIDTH-1:0] s0_q, s1_q;
    logic                    v0_q, v1_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v0_q         <= 1'b0;
        v1_q         <= 1'b0;
        dout_valid_q <= 1'b0;
        dout_q       <= '0;
        s0_q         <= '0;
        s1_q         <= '0;
      end else begin
        v0_q         <= rd_acc;
        v1_q         <= v0_q;
        dout_valid_q <= v1_q;
        if (rd_acc) s0_q   <= rd_word;
        if (v0_q)   s1_q   <= s0_q;
        if (v1_q)   dout_q <= s1_q;
      end
    end
  end else begin : g_rd_ll
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_valid_q <= 1'b0;
        dout_q       <= '0;
      end else begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= rd_word;
      end
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire
